ps2_key_tracker: RTL

//  Consumer stage behind ps2_keyboard: pops scan-code bytes from its FIFO (data/ready/nextdata_n),

---
 rtl/ps2_key_tracker.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code consumer: pops bytes from the keyboard FIFO, decodes E0/F0 make/break
// sequences, tracks the held key, maps it to ASCII and counts presses. Option: SHIFT_CASE_EN.
module ps2_key_tracker #(
  parameter int POP_GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data,
  input  logic       ready,
  input  logic       overflow,
  output logic       nextdata_n,
  output logic       key_down,
  output logic [7:0] scan_code,
  output logic       ext,
  output logic [7:0] ascii,
  output logic [7:0] press_cnt,
  output logic       new_key,
  output logic       ovf_seen
);

  localparam int GW = (POP_GAP > 1) ? $clog2(POP_GAP) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_POP,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [GW-1:0]   r_gap_cnt;
  logic            w_consume;
  logic            w_nextdata_n;

  logic            r_pfx_ext;
  logic            r_pfx_brk;
  logic            r_key_down;
  logic [7:0]      r_scan_code;
  logic            r_ext;
  logic [7:0]      r_ascii;
  logic [7:0]      r_press_cnt;
  logic            r_new_key;
  logic            r_ovf_seen;

  logic            w_is_e0;
  logic            w_is_f0;
  logic            w_same_key;
  logic            w_is_shift;
  logic            w_shift_held;

  // Letter/digit/control map for non-extended codes; upper folds a-z to A-Z.
  function automatic logic [7:0] f_map(input logic [7:0] b, input logic upper);
    logic [7:0] c;
    c = 8'h00;
    case (b)
      8'h1C: c = 8'h61;  8'h32: c = 8'h62;  8'h21: c = 8'h63;  8'h23: c = 8'h64;
      8'h24: c = 8'h65;  8'h2B: c = 8'h66;  8'h34: c = 8'h67;  8'h33: c = 8'h68;
      8'h43: c = 8'h69;  8'h3B: c = 8'h6A;  8'h42: c = 8'h6B;  8'h4B: c = 8'h6C;
      8'h3A: c = 8'h6D;  8'h31: c = 8'h6E;  8'h44: c = 8'h6F;  8'h4D: c = 8'h70;
      8'h15: c = 8'h71;  8'h2D: c = 8'h72;  8'h1B: c = 8'h73;  8'h2C: c = 8'h74;
      8'h3C: c = 8'h75;  8'h2A: c = 8'h76;  8'h1D: c = 8'h77;  8'h22: c = 8'h78;
      8'h35: c = 8'h79;  8'h1A: c = 8'h7A;
      8'h45: c = 8'h30;  8'h16: c = 8'h31;  8'h1E: c = 8'h32;  8'h26: c = 8'h33;
      8'h25: c = 8'h34;  8'h2E: c = 8'h35;  8'h36: c = 8'h36;  8'h3D: c = 8'h37;
      8'h3E: c = 8'h38;  8'h46: c = 8'h39;
      8'h29: c = 8'h20;  8'h5A: c = 8'h0D;  8'h66: c = 8'h08;
      default: c = 8'h00;
    endcase
    if (upper && c >= 8'h61 && c <= 8'h7A) c = c - 8'h20;
    return c;
  endfunction

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_gap_cnt <= (r_state == S_WAIT) ? r_gap_cnt + 1'b1 : '0;
    end
  end

  // NOTE: next state defaults to the current state first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ready) w_state_nxt = S_POP;
      S_POP:   w_state_nxt = S_WAIT;
      S_WAIT:  if (r_gap_cnt == GW'(POP_GAP - 1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_nextdata_n = (r_state != S_POP);
    w_consume    = (r_state == S_IDLE) && ready;
  end

  assign w_is_e0    = (data == 8'hE0);
  assign w_is_f0    = (data == 8'hF0);
  assign w_same_key = (data == r_scan_code) && (r_pfx_ext == r_ext);

`ifdef SHIFT_CASE_EN
  logic r_shift_held;

  assign w_is_shift   = ((data == 8'h12) || (data == 8'h59)) && !r_pfx_ext;
  assign w_shift_held = r_shift_held;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_shift_held <= 1'b0;
    else if (w_consume && w_is_shift)
      r_shift_held <= !r_pfx_brk;
  end
`else
  assign w_is_shift   = 1'b0;
  assign w_shift_held = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pfx_ext   <= 1'b0;
      r_pfx_brk   <= 1'b0;
      r_key_down  <= 1'b0;
      r_scan_code <= 8'h00;
      r_ext       <= 1'b0;
      r_ascii     <= 8'h00;
      r_press_cnt <= 8'h00;
      r_new_key   <= 1'b0;
      r_ovf_seen  <= 1'b0;
    end else begin
      r_new_key <= 1'b0;
      if (overflow) r_ovf_seen <= 1'b1;
      if (w_consume) begin
        if (w_is_e0) begin
          r_pfx_ext <= 1'b1;
        end else if (w_is_f0) begin
          r_pfx_brk <= 1'b1;
        end else begin
          r_pfx_ext <= 1'b0;
          r_pfx_brk <= 1'b0;
          if (w_is_shift) begin
            // Shift keys only steer case inside their own register.
          end else if (r_pfx_brk) begin
            if (w_same_key) r_key_down <= 1'b0;
          end else if (!(r_key_down && w_same_key)) begin
            r_scan_code <= data;
            r_ext       <= r_pfx_ext;
            r_key_down  <= 1'b1;
            r_ascii     <= r_pfx_ext ? 8'h00 : f_map(data, w_shift_held);
            r_press_cnt <= r_press_cnt + 8'd1;
            r_new_key   <= 1'b1;
          end
        end
      end
    end
  end

  assign nextdata_n = w_nextdata_n;
  assign key_down   = r_key_down;
  assign scan_code  = r_scan_code;
  assign ext        = r_ext;
  assign ascii      = r_ascii;
  assign press_cnt  = r_press_cnt;
  assign new_key    = r_new_key;
  assign ovf_seen   = r_ovf_seen;

endmodule
